// File: rtl/gpio_pkg.sv
// Shared GPIO register offsets, access-size encodings and the write-lane placement helper.
// Pulled into gpio and gpio_in_filter with import gpio_pkg::*.
package gpio_pkg;

    localparam logic [2:0] OFF_IN   = 3'd0;
    localparam logic [2:0] OFF_OUT  = 3'd1;
    localparam logic [2:0] OFF_DIR  = 3'd2;
    localparam logic [2:0] OFF_SET  = 3'd3;
    localparam logic [2:0] OFF_CLR  = 3'd4;
    localparam logic [2:0] OFF_RISE = 3'd5;
    localparam logic [2:0] OFF_FALL = 3'd6;
    localparam logic [2:0] OFF_PEND = 3'd7;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic        ok;
        logic [31:0] mask;
        logic [31:0] data;
    } lane_t;

    // Moves sub-word write data into the byte lanes selected by the low address bits.
    function automatic lane_t lane_place(input logic [1:0] sz, input logic [1:0] lo,
                                         input logic [31:0] wd);
        lane_t l;
        l.ok = 1'b1;
        case (sz)
            SIZE_B: begin
                l.mask = 32'h0000_00FF << {lo, 3'b000};
                l.data = {24'h0, wd[7:0]} << {lo, 3'b000};
            end
            SIZE_H: begin
                l.ok   = ~lo[0];
                l.mask = 32'h0000_FFFF << {lo[1], 4'b0000};
                l.data = {16'h0, wd[15:0]} << {lo[1], 4'b0000};
            end
            default: begin
                l.mask = '1;
                l.data = wd;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/gpio_in_filter.sv
// Pin input conditioning: 2-flop synchroniser, optionally followed by a per-pin debounce
// filter when GPIO_DEBOUNCE_EN is defined.
module gpio_in_filter
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Counts consecutive disagreeing cycles; the pin flips on the last one.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        logic [CW-1:0] cnt;
        logic          stable;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt    <= '0;
                stable <= 1'b0;
            end else if (sync2[i] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= sync2[i];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign dout[i] = stable;
    end
`else
    assign dout = sync2;
`endif

endmodule

// File: rtl/gpio.sv
// Memory-mapped GPIO port: direction, atomic set/clear, synchronised inputs and sticky
// edge interrupts. Define GPIO_DEBOUNCE_EN to add the input debounce filter.
module gpio
    import gpio_pkg::*;
#(
    parameter int          WIDTH           = 32,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [2:0]       size,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    logic             hit;
    logic             wr;
    logic [2:0]       off;
    lane_t            lane_w;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wval;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pend_nxt;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] dir_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;
    logic [1:0]       armed_cnt;
    logic             armed;
    logic [31:0]      rd_nxt;
    logic             unused_bits;

    gpio_in_filter #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
        .clk (clk),
        .rstn(rstn),
        .din (gpio_in),
        .dout(stable)
    );

    assign hit         = (addr[31:5] == BASE_ADDR[31:5]);
    assign off         = addr[4:2];
    assign lane_w      = lane_place(size[1:0], addr[1:0], wd);
    assign wr          = we & hit & lane_w.ok;
    assign wmask       = lane_w.mask[WIDTH-1:0];
    assign wval        = lane_w.data[WIDTH-1:0] & wmask;
    assign unused_bits = ^{size[2], lane_w};

    always_comb begin
        out_nxt  = gpio_out;
        dir_nxt  = gpio_oe;
        rise_nxt = rise_en;
        fall_nxt = fall_en;
        w1c      = '0;
        if (wr) begin
            case (off)
                OFF_OUT:  out_nxt  = (gpio_out & ~wmask) | wval;
                OFF_DIR:  dir_nxt  = (gpio_oe & ~wmask) | wval;
                OFF_SET:  out_nxt  = gpio_out | wval;
                OFF_CLR:  out_nxt  = gpio_out & ~wval;
                OFF_RISE: rise_nxt = (rise_en & ~wmask) | wval;
                OFF_FALL: fall_nxt = (fall_en & ~wmask) | wval;
                OFF_PEND: w1c      = wval;
                default:  ;
            endcase
        end
    end

    // Edges stay masked for three cycles after reset so pins held high do not fire.
    assign armed    = (armed_cnt == 2'd3);
    assign rise     = stable & ~prev & rise_en & {WIDTH{armed}};
    assign fall     = ~stable & prev & fall_en & {WIDTH{armed}};
    assign pend_nxt = (pending & ~w1c) | rise | fall;

    always_comb begin
        rd_nxt = '0;
        if (hit) begin
            case (off)
                OFF_IN:   rd_nxt[WIDTH-1:0] = stable;
                OFF_OUT:  rd_nxt[WIDTH-1:0] = gpio_out;
                OFF_DIR:  rd_nxt[WIDTH-1:0] = gpio_oe;
                OFF_RISE: rd_nxt[WIDTH-1:0] = rise_en;
                OFF_FALL: rd_nxt[WIDTH-1:0] = fall_en;
                OFF_PEND: rd_nxt[WIDTH-1:0] = pending;
                default:  ;
            endcase
        end
    end

    // irq trails PENDING by one register stage: pin edge to irq is 2 sync + 1 pending + 1 irq.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd        <= '0;
            gpio_out  <= '0;
            gpio_oe   <= '0;
            rise_en   <= '0;
            fall_en   <= '0;
            pending   <= '0;
            prev      <= '0;
            armed_cnt <= '0;
            irq       <= 1'b0;
        end else begin
            rd        <= rd_nxt;
            gpio_out  <= out_nxt;
            gpio_oe   <= dir_nxt;
            rise_en   <= rise_nxt;
            fall_en   <= fall_nxt;
            pending   <= pend_nxt;
            prev      <= stable;
            armed_cnt <= armed ? armed_cnt : armed_cnt + 2'd1;
            irq       <= |pending;
        end
    end

endmodule

// File: tb/tb_gpio.sv
// Self-checking bench for gpio: directed register table, timed interrupt sequences and a
// randomized run against a queue-based pin/register model.
module tb_gpio;

    localparam logic [31:0] BASE   = 32'h1000_0040;
    localparam logic [31:0] O_IN   = 32'h00;
    localparam logic [31:0] O_OUT  = 32'h04;
    localparam logic [31:0] O_DIR  = 32'h08;
    localparam logic [31:0] O_SET  = 32'h0C;
    localparam logic [31:0] O_CLR  = 32'h10;
    localparam logic [31:0] O_RISE = 32'h14;
    localparam logic [31:0] O_FALL = 32'h18;
    localparam logic [31:0] O_PEND = 32'h1C;
    localparam int          DB     = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int          EXTRA  = DB;
`else
    localparam int          EXTRA  = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [2:0]  size = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        irq;

    always #5 clk = ~clk;

    gpio #(.WIDTH(32), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rstn(rstn), .we(we), .addr(addr), .size(size), .wd(wd), .rd(rd),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        we = 1'b1; addr = a; size = s; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        we = 1'b0; addr = a;
        tick();
        d = rd;
    endtask

    task automatic settle();
        bus_wr(BASE + O_RISE, 3'd2, 32'h0);
        bus_wr(BASE + O_FALL, 3'd2, 32'h0);
        gpio_in = '0;
        repeat (6 + EXTRA) tick();
        bus_wr(BASE + O_PEND, 3'd2, 32'hFFFF_FFFF);
        tick();
        tick();
    endtask

    // Byte-lane view of a bus write: which bytes change and with what.
    function automatic void lane_m(input logic [1:0] sz, input logic [1:0] lo,
                                   input logic [31:0] d, output logic [31:0] m,
                                   output logic [31:0] v);
        int loi;
        loi = int'(lo);
        m = '0;
        v = '0;
        for (int b = 0; b < 4; b++) begin
            bit en;
            int src;
            case (sz)
                2'd0:    begin en = (b == loi); src = 0; end
                2'd1:    begin en = (loi % 2 == 0) && (b == loi || b == loi + 1); src = b - loi; end
                default: begin en = 1'b1; src = b; end
            endcase
            if (en) begin
                m[8*b +: 8] = 8'hFF;
                v[8*b +: 8] = d[8*src +: 8];
            end
        end
    endfunction

    typedef struct packed {
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] d;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #200000;
        $display("FAIL timeout watchdog");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] p [4];
        logic [31:0] m_out, m_dir, m_rise, m_fall, m_pend, prev_m, st_m, stable_b;
        int          run [32];
        bit          seen;

        tbl[0]  = '{BASE + O_OUT,     3'd2, 32'h0000_00F0, BASE + O_OUT,  32'h0000_00F0};
        tbl[1]  = '{BASE + O_SET,     3'd2, 32'h0000_000F, BASE + O_OUT,  32'h0000_00FF};
        tbl[2]  = '{BASE + O_CLR,     3'd2, 32'h0000_0030, BASE + O_OUT,  32'h0000_00CF};
        tbl[3]  = '{BASE + O_DIR,     3'd2, 32'h0000_00FF, BASE + O_DIR,  32'h0000_00FF};
        tbl[4]  = '{BASE + O_OUT,     3'd2, 32'h1122_3344, BASE + O_OUT,  32'h1122_3344};
        tbl[5]  = '{BASE + O_OUT + 1, 3'd0, 32'h0000_00AB, BASE + O_OUT,  32'h1122_AB44};
        tbl[6]  = '{BASE + O_OUT + 1, 3'd1, 32'h0000_5555, BASE + O_OUT,  32'h1122_AB44};
        tbl[7]  = '{BASE + O_OUT + 2, 3'd1, 32'h0000_BEEF, BASE + O_OUT,  32'hBEEF_AB44};
        tbl[8]  = '{BASE + O_SET + 3, 3'd0, 32'h0000_0001, BASE + O_OUT,  32'hBFEF_AB44};
        tbl[9]  = '{BASE + O_CLR + 2, 3'd0, 32'h0000_00FF, BASE + O_OUT,  32'hBF00_AB44};
        tbl[10] = '{BASE + O_SET,     3'd3, 32'h0000_00BB, BASE + O_OUT,  32'hBF00_ABFF};
        tbl[11] = '{32'h1000_0004,    3'd2, 32'h0000_0000, BASE + O_OUT,  32'hBF00_ABFF};
        tbl[12] = '{BASE + O_FALL,    3'd2, 32'h0000_00A5, BASE + O_FALL, 32'h0000_00A5};
        tbl[13] = '{BASE + O_IN,      3'd2, 32'hFFFF_FFFF, BASE + O_SET,  32'h0000_0000};
        tbl[14] = '{BASE + O_FALL + 1,3'd4, 32'h0000_003C, BASE + O_FALL, 32'h0000_3CA5};
        tbl[15] = '{BASE + O_FALL,    3'd2, 32'h0000_0000, BASE + O_FALL, 32'h0000_0000};

        // Reset with all pins high, then enable every rising edge.
        gpio_in = '1;
        repeat (3) tick();
        check("reset_rd", rd, 32'h0);
        check("reset_out", gpio_out, 32'h0);
        check("reset_oe", gpio_oe, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        rstn = 1'b1;
        bus_wr(BASE + O_RISE, 3'd2, 32'hFFFF_FFFF);
        addr = BASE + O_IN;
        for (int c = 2; c <= 12; c++) begin
            tick();
            if (c >= 4 + EXTRA) check("in_after_reset", rd, 32'hFFFF_FFFF);
`ifndef GPIO_DEBOUNCE_EN
            check("irq_after_reset", {31'h0, irq}, 32'h0);
`endif
        end
`ifndef GPIO_DEBOUNCE_EN
        bus_rd(BASE + O_PEND, r);
        check("pend_after_reset", r, 32'h0);
`endif
        settle();

`ifdef GPIO_DEBOUNCE_EN
        // Short glitch is filtered out, a longer pulse gets through.
        seen = 1'b0;
        addr = BASE + O_IN;
        gpio_in[0] = 1'b1;
        repeat (3) tick();
        gpio_in[0] = 1'b0;
        repeat (12) begin tick(); seen |= rd[0]; end
        check("debounce_glitch", {31'h0, seen}, 32'h0);
        seen = 1'b0;
        gpio_in[0] = 1'b1;
        repeat (6) begin tick(); seen |= rd[0]; end
        gpio_in[0] = 1'b0;
        repeat (12) begin tick(); seen |= rd[0]; end
        check("debounce_pulse", {31'h0, seen}, 32'h1);
        settle();
`endif

        for (int i = 0; i < 16; i++) begin
            bus_wr(tbl[i].a, tbl[i].s, tbl[i].d);
            bus_rd(tbl[i].ra, r);
            check($sformatf("vec%0d", i), r, tbl[i].exp);
        end
        check("table_out_pins", gpio_out, 32'hBF00_ABFF);
        check("table_oe_pins", gpio_oe, 32'h0000_00FF);

        // Rising edge on pin 0: PENDING visible after 3 edges, irq after 4.
        bus_wr(BASE + O_RISE, 3'd2, 32'h1);
        gpio_in[0] = 1'b1;
        addr = BASE + O_PEND;
        for (int c = 1; c <= 4 + EXTRA; c++) begin
            tick();
            if (c == 3 + EXTRA) begin
                check("irq_before_lat", {31'h0, irq}, 32'h0);
                check("pend_before_lat", rd, 32'h0);
            end
            if (c == 4 + EXTRA) begin
                check("irq_at_lat", {31'h0, irq}, 32'h1);
                check("pend_at_lat", rd, 32'h1);
            end
        end
        bus_wr(BASE + O_PEND, 3'd2, 32'h1);
        tick();
        check("irq_after_w1c", {31'h0, irq}, 32'h0);
        check("pend_after_w1c", rd, 32'h0);

        // Falling edge on pin 3 lands on the same edge as its W1C: set wins.
        bus_wr(BASE + O_FALL, 3'd2, 32'h8);
        gpio_in[3] = 1'b1;
        repeat (6 + EXTRA) tick();
        gpio_in[3] = 1'b0;
        repeat (2 + EXTRA) tick();
        bus_wr(BASE + O_PEND, 3'd2, 32'h8);
        bus_rd(BASE + O_PEND, r);
        check("pend_set_wins", r, 32'h8);
        check("irq_set_wins", {31'h0, irq}, 32'h1);
        bus_wr(BASE + O_PEND, 3'd0, 32'h8);
        bus_rd(BASE + O_PEND, r);
        check("pend_byte_w1c", r, 32'h0);

        // Randomized run against the model.
        bus_wr(BASE + O_OUT, 3'd2, 32'h0);
        bus_wr(BASE + O_DIR, 3'd2, 32'h0);
        settle();
        m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        prev_m = '0; st_m = '0;
        for (int i = 0; i < 4; i++) p[i] = '0;
        for (int i = 0; i < 32; i++) run[i] = 0;

        for (int n = 0; n < 400; n++) begin
            logic [31:0] pins_n, a, d, m, v, exp_rd, w1c, rise, fall;
            logic [2:0]  off;
            logic [1:0]  lo, sz;
            bit          we_r, hit_r, irq_exp;

            pins_n = gpio_in;
            if ($urandom_range(3) == 0) pins_n = pins_n ^ ($urandom & $urandom & $urandom);
            we_r  = ($urandom_range(9) < 6);
            off   = 3'($urandom_range(7));
            lo    = 2'($urandom_range(3));
            sz    = 2'($urandom_range(3));
            hit_r = ($urandom_range(9) != 0);
            d     = $urandom;
            a     = (hit_r ? BASE : (BASE ^ 32'h0000_0100)) + {27'h0, off, 2'b00} + {30'h0, lo};

            we = we_r; addr = a; size = {1'($urandom_range(1)), sz}; wd = d; gpio_in = pins_n;
            tick();

            p[3] = p[2]; p[2] = p[1]; p[1] = p[0]; p[0] = pins_n;
`ifdef GPIO_DEBOUNCE_EN
            stable_b = st_m;
`else
            stable_b = p[2];
`endif
            exp_rd = '0;
            if (hit_r) begin
                case (off)
                    3'd0: exp_rd = stable_b;
                    3'd1: exp_rd = m_out;
                    3'd2: exp_rd = m_dir;
                    3'd5: exp_rd = m_rise;
                    3'd6: exp_rd = m_fall;
                    3'd7: exp_rd = m_pend;
                    default: exp_rd = '0;
                endcase
            end
            irq_exp = |m_pend;
            rise = stable_b & ~prev_m & m_rise;
            fall = ~stable_b & prev_m & m_fall;
            lane_m(sz, lo, d, m, v);
            w1c = '0;
            if (we_r && hit_r) begin
                case (off)
                    3'd1: m_out  = (m_out & ~m) | v;
                    3'd2: m_dir  = (m_dir & ~m) | v;
                    3'd3: m_out  = m_out | v;
                    3'd4: m_out  = m_out & ~v;
                    3'd5: m_rise = (m_rise & ~m) | v;
                    3'd6: m_fall = (m_fall & ~m) | v;
                    3'd7: w1c    = v;
                    default: ;
                endcase
            end
            m_pend = (m_pend & ~w1c) | rise | fall;
            prev_m = stable_b;
            for (int b = 0; b < 32; b++) begin
                if (p[1][b] != st_m[b]) begin
                    run[b]++;
                    if (run[b] == DB) begin st_m[b] = p[1][b]; run[b] = 0; end
                end else begin
                    run[b] = 0;
                end
            end

            check("rand_rd", rd, exp_rd);
            check("rand_out", gpio_out, m_out);
            check("rand_oe", gpio_oe, m_dir);
            check("rand_irq", {31'h0, irq}, {31'h0, irq_exp});
        end
        we = 1'b0;

        // Asynchronous reset in the middle of a cycle clears everything at once.
        bus_wr(BASE + O_OUT, 3'd2, 32'h5A);
        bus_wr(BASE + O_DIR, 3'd2, 32'h3C);
        check("pre_async_out", gpio_out, 32'h5A);
        #2;
        rstn = 1'b0;
        #1;
        check("async_out", gpio_out, 32'h0);
        check("async_oe", gpio_oe, 32'h0);
        check("async_irq", {31'h0, irq}, 32'h0);
        tick();
        rstn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
